// File: rtl/noc_local_port.sv
// rtl/noc_local_port.sv - local core network interface for one mesh router port
//
// Purpose: TX FIFO plus initiator FSM injecting core flits into the router,
// and a responder FSM plus RX FIFO accepting flits from the router for the core.
// Sticky error flags and saturating flit counters are provided for debug.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   tx_push, tx_dest, tx_data      core flit write into the TX FIFO
//   tx_full                        TX FIFO full (registered)
//   out_addr, out_data, out_valid  flit towards the router
//   from_out_ack                   one-cycle ack from the router
//   in_addr, in_data, in_valid     flit from the router
//   to_in_ack                      one-cycle ack towards the router
//   rx_valid, rx_addr, rx_data     head of the RX FIFO
//   rx_pop                         core consumes the RX head
//   err_flags                      sticky [0] TX overflow, [1] self push, [2] misroute
//   tx_count, rx_count             saturating flit counters
module noc_local_port #(
  parameter int NODE_ADDR  = 7,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_push,
  input  logic [ADDR_W-1:0] tx_dest,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              from_out_ack,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              to_in_ack,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] rx_addr,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_pop,
  output logic [2:0]        err_flags,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int FLIT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] SELF_C  = ADDR_W'(NODE_ADDR);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_DRAIN} rx_state_t;

  // TX side state
  logic [FLIT_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PTR_W-1:0]  tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_full_q, tx_full_d;
  tx_state_t         tx_state_q, tx_state_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic              tx_we, tx_rd, tx_ovf, tx_self;
  logic [FLIT_W-1:0] tx_head;

  // RX side state
  logic [FLIT_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PTR_W-1:0]  rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  rx_state_t         rx_state_q, rx_state_d;
  logic              to_in_ack_q, to_in_ack_d;
  logic [15:0]       rx_count_q, rx_count_d;
  logic              rx_we, rx_rd, rx_space, rx_misroute;
  logic [FLIT_W-1:0] rx_head;

  logic [2:0]        err_flags_q, err_flags_d;

  assign tx_head = tx_mem[tx_rd_ptr_q];
  assign rx_head = rx_mem[rx_rd_ptr_q];

  // TX FIFO write side and initiator FSM
  always_comb begin
    tx_state_d  = tx_state_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tx_count_d  = tx_count_q;
    tx_rd       = 1'b0;

    // Full is judged on current occupancy so tx_full seen by the core is authoritative.
    tx_ovf  = tx_push && (tx_cnt_q == DEPTH_C);
    tx_self = tx_push && (tx_dest == SELF_C);
    tx_we   = tx_push && !tx_ovf && !tx_self;

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_cnt_q != '0) begin
          out_addr_d  = tx_head[FLIT_W-1:DATA_W];
          out_data_d  = tx_head[DATA_W-1:0];
          out_valid_d = 1'b1;
          tx_rd       = 1'b1;
          tx_state_d  = TX_SEND;
        end
      end
      TX_SEND: begin
        if (from_out_ack) begin
          out_addr_d  = '0;
          out_data_d  = '0;
          out_valid_d = 1'b0;
          tx_count_d  = (tx_count_q == 16'hFFFF) ? tx_count_q : tx_count_q + 16'd1;
          tx_state_d  = TX_GAP;
        end
      end
      TX_GAP:  tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase

    tx_wr_ptr_d = tx_we ? tx_wr_ptr_q + PTR_W'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd ? tx_rd_ptr_q + PTR_W'(1) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q + CNT_W'(tx_we) - CNT_W'(tx_rd);
    tx_full_d   = (tx_cnt_d == DEPTH_C);
  end

  // Responder FSM and RX FIFO
  always_comb begin
    rx_state_d  = rx_state_q;
    to_in_ack_d = 1'b0;
    rx_count_d  = rx_count_q;
    rx_we       = 1'b0;
    rx_misroute = 1'b0;

    rx_rd    = rx_pop && (rx_cnt_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    rx_space = (rx_cnt_q != DEPTH_C) || rx_pop;

    case (rx_state_q)
      RX_IDLE: begin
        if (in_valid && rx_space) begin
          to_in_ack_d = 1'b1;
          rx_state_d  = RX_ACK;
          if (in_addr == SELF_C) begin
            rx_we      = 1'b1;
            rx_count_d = (rx_count_q == 16'hFFFF) ? rx_count_q : rx_count_q + 16'd1;
          end else begin
            rx_misroute = 1'b1;
          end
        end
      end
      RX_ACK:  rx_state_d = RX_DRAIN;
      // Wait for the router to drop valid so the same flit is not captured twice.
      RX_DRAIN: begin
        if (!in_valid) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    rx_wr_ptr_d = rx_we ? rx_wr_ptr_q + PTR_W'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd ? rx_rd_ptr_q + PTR_W'(1) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + CNT_W'(rx_we) - CNT_W'(rx_rd);
  end

  always_comb begin
    err_flags_d = err_flags_q | {rx_misroute, tx_self, tx_ovf};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_state_q  <= RX_IDLE;
      to_in_ack_q <= 1'b0;
      rx_count_q  <= '0;
      err_flags_q <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_full_q   <= tx_full_d;
      tx_state_q  <= tx_state_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_state_q  <= rx_state_d;
      to_in_ack_q <= to_in_ack_d;
      rx_count_q  <= rx_count_d;
      err_flags_q <= err_flags_d;
    end
  end

  // Storage needs no reset: occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_wr_ptr_q] <= {tx_dest, tx_data};
    if (rx_we) rx_mem[rx_wr_ptr_q] <= {in_addr, in_data};
  end

  assign tx_full   = tx_full_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign to_in_ack = to_in_ack_q;
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_addr   = rx_valid ? rx_head[FLIT_W-1:DATA_W] : '0;
  assign rx_data   = rx_valid ? rx_head[DATA_W-1:0] : '0;
  assign err_flags = err_flags_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_noc_local_port.sv
// tb/tb_noc_local_port.sv - scoreboard bench for noc_local_port
module tb_noc_local_port;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NODE   = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tx_push = 1'b0;
  logic [ADDR_W-1:0] tx_dest = '0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_full;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              from_out_ack = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              to_in_ack;
  logic              rx_valid;
  logic [ADDR_W-1:0] rx_addr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_pop = 1'b0;
  logic [2:0]        err_flags;
  logic [15:0]       tx_count;
  logic [15:0]       rx_count;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] sb_tx[$];
  logic [ADDR_W+DATA_W-1:0] sb_rx[$];
  logic [15:0] exp_tx_count = '0;
  logic [15:0] exp_rx_count = '0;

  noc_local_port #(
    .NODE_ADDR(NODE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_push(tx_push), .tx_dest(tx_dest), .tx_data(tx_data), .tx_full(tx_full),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid),
    .from_out_ack(from_out_ack),
    .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .to_in_ack(to_in_ack),
    .rx_valid(rx_valid), .rx_addr(rx_addr), .rx_data(rx_data), .rx_pop(rx_pop),
    .err_flags(err_flags), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    sb_tx.delete();
    sb_rx.delete();
    exp_tx_count = '0;
    exp_rx_count = '0;
  endtask

  task automatic push_tx(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data,
                         input bit store);
    tx_dest = dest;
    tx_data = data;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    if (store) sb_tx.push_back({dest, data});
  endtask

  task automatic wait_tx_valid(output int low);
    low = 0;
    while (!out_valid && low < 20) begin
      tick();
      low++;
    end
    check("tx_valid_seen", 64'(out_valid), 64'd1);
  endtask

  // Router side of TX: holds ack off for 'hold' cycles, checking the flit stays stable.
  task automatic ack_tx(input int hold);
    logic [ADDR_W+DATA_W-1:0] exp;
    check("tx_sb_nonempty", 64'(sb_tx.size() != 0), 64'd1);
    exp = (sb_tx.size() != 0) ? sb_tx.pop_front() : '0;
    check("tx_flit", 64'({out_addr, out_data}), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("tx_hold_valid", 64'(out_valid), 64'd1);
      check("tx_hold_flit", 64'({out_addr, out_data}), 64'(exp));
    end
    from_out_ack = 1'b1;
    tick();
    from_out_ack = 1'b0;
    exp_tx_count++;
    check("tx_valid_drop", 64'({out_valid, out_addr, out_data}), 64'd0);
    check("tx_count", 64'(tx_count), 64'(exp_tx_count));
  endtask

  // Router side of RX: present flit, wait for ack, optionally hold valid extra cycles.
  task automatic rx_send(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input int hold_extra);
    int n;
    int acks;
    in_addr  = addr;
    in_data  = data;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!to_in_ack && n < 20);
    check("rx_ack_seen", 64'(to_in_ack), 64'd1);
    acks = to_in_ack ? 1 : 0;
    if (addr == ADDR_W'(NODE)) begin
      sb_rx.push_back({addr, data});
      exp_rx_count++;
    end
    tick();
    acks += to_in_ack ? 1 : 0;
    for (int i = 0; i < hold_extra; i++) begin
      tick();
      acks += to_in_ack ? 1 : 0;
    end
    in_valid = 1'b0;
    tick();
    acks += to_in_ack ? 1 : 0;
    check("rx_ack_once", 64'(acks), 64'd1);
  endtask

  task automatic rx_pop_check();
    logic [ADDR_W+DATA_W-1:0] exp;
    check("rx_head_valid", 64'(rx_valid), 64'd1);
    exp = (sb_rx.size() != 0) ? sb_rx.pop_front() : '0;
    check("rx_head_flit", 64'({rx_addr, rx_data}), 64'(exp));
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    bit seen;
    bit ackseen;

    // Reset state
    do_reset();
    check("rst_tx_out", 64'({out_valid, out_addr, out_data}), 64'd0);
    check("rst_flags", 64'({to_in_ack, tx_full, rx_valid, err_flags}), 64'd0);
    check("rst_rx_head", 64'({rx_addr, rx_data}), 64'd0);
    check("rst_counts", 64'({tx_count, rx_count}), 64'd0);

    // Single TX: flit appears two cycles after the push cycle, acked 3 cycles later
    tx_dest = 5'd8;
    tx_data = 32'hDEADBEEF;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    sb_tx.push_back({5'd8, 32'hDEADBEEF});
    check("tx_lat_early", 64'(out_valid), 64'd0);
    tick();
    check("tx_lat_rise", 64'(out_valid), 64'd1);
    ack_tx(2);
    tick();
    check("tx_gap_low", 64'(out_valid), 64'd0);
    repeat (3) tick();

    // TX backpressure and overflow: 1 in SEND + 4 in FIFO, the 6th is dropped
    for (int i = 0; i < 5; i++) push_tx(5'(10 + i), 32'hA000_0000 + 32'(i), 1'b1);
    check("tx_full_set", 64'(tx_full), 64'd1);
    check("tx_no_ovf_yet", 64'(err_flags[0]), 64'd0);
    push_tx(5'd20, 32'hBAD0_0006, 1'b0);
    check("tx_ovf_flag", 64'(err_flags[0]), 64'd1);
    check("tx_full_hold", 64'(tx_full), 64'd1);
    for (int i = 0; i < 5; i++) begin
      wait_tx_valid(low);
      if (i > 0) check("tx_gap_min", 64'(low >= 1), 64'd1);
      ack_tx(i % 2);
    end
    check("tx_sb_empty", 64'(sb_tx.size()), 64'd0);
    check("tx_full_clear", 64'(tx_full), 64'd0);
    check("tx_count_total", 64'(tx_count), 64'd6);

    // Self-addressed push is discarded
    do_reset();
    push_tx(5'(NODE), 32'hCAFEF00D, 1'b0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("self_no_valid", 64'(seen), 64'd0);
    check("self_err", 64'(err_flags), 64'b010);
    check("self_tx_count", 64'(tx_count), 64'd0);

    // RX normal with router holding valid one extra cycle
    rx_send(5'(NODE), 32'h12345678, 1);
    check("rx_count_1", 64'(rx_count), 64'(exp_rx_count));
    check("rx_data_1", 64'(rx_data), 64'h12345678);
    rx_pop_check();
    check("rx_empty_after_pop", 64'(rx_valid), 64'd0);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    check("rx_pop_empty_ignored", 64'({rx_valid, rx_count}), 64'(exp_rx_count));

    // RX full: fifth flit waits for a pop
    for (int i = 0; i < 4; i++) rx_send(5'(NODE), 32'h5000_0000 + 32'(i), 0);
    check("rx_count_5", 64'(rx_count), 64'(exp_rx_count));
    in_addr  = 5'(NODE);
    in_data  = 32'h5000_0004;
    in_valid = 1'b1;
    ackseen  = 1'b0;
    repeat (4) begin
      tick();
      if (to_in_ack) ackseen = 1'b1;
    end
    check("rx_backpressure", 64'(ackseen), 64'd0);
    rx_pop_check();
    check("rx_full_accept", 64'(to_in_ack), 64'd1);
    sb_rx.push_back({5'(NODE), 32'h5000_0004});
    exp_rx_count++;
    tick();
    check("rx_full_ack_pulse", 64'(to_in_ack), 64'd0);
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) rx_pop_check();
    check("rx_drained", 64'(rx_valid), 64'd0);
    check("rx_count_6", 64'(rx_count), 64'(exp_rx_count));

    // Misrouted flit: acked, not stored, flagged
    rx_send(5'd9, 32'h0BADF00D, 0);
    check("misroute_err", 64'(err_flags[2]), 64'd1);
    check("misroute_not_stored", 64'({rx_valid, rx_count}), 64'(exp_rx_count));

    // Async reset mid-cycle with TX valid and RX ack both high
    tx_dest = 5'd8;
    tx_data = 32'h77777777;
    tx_push = 1'b1;
    tick();
    tx_push  = 1'b0;
    in_addr  = 5'(NODE);
    in_data  = 32'h66666666;
    in_valid = 1'b1;
    tick();
    check("pre_rst_busy", 64'({out_valid, to_in_ack}), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", 64'({out_valid, out_addr, out_data}), 64'd0);
    check("async_rst_flags", 64'({to_in_ack, tx_full, rx_valid, err_flags}), 64'd0);
    check("async_rst_rx", 64'({rx_addr, rx_data}), 64'd0);
    check("async_rst_counts", 64'({tx_count, rx_count}), 64'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid || rx_valid) seen = 1'b1;
    end
    check("post_rst_fifos_empty", 64'({seen, tx_full}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
